seq_mul32: RTL

SEQ_MUL32 -- requirements
Module: seq_mul32

---
 rtl/seq_mul32_if.sv | 28 ++
 rtl/seq_mul32.sv | 101 ++++++++++
 2 files changed

// File: rtl/seq_mul32_if.sv
// Request/response bundle for the sequential Booth multiplier.
// Master issues operands and start; slave reports busy, done and the product.
interface seq_mul32_if;
    logic        start;
    logic [31:0] RegA;
    logic [31:0] RegB;
    logic        busy;
    logic        done;
    logic [63:0] Z;

    modport master (
        output start,
        output RegA,
        output RegB,
        input  busy,
        input  done,
        input  Z
    );

    modport slave (
        input  start,
        input  RegA,
        input  RegB,
        output busy,
        output done,
        output Z
    );
endinterface

// File: rtl/seq_mul32.sv
// 32x32 signed radix-2 Booth multiplier, one Booth step per clock.
// Fixed 32-step latency; Z is registered and only updated on completion.
module seq_mul32 (
    input  logic         clk,
    input  logic         clr,
    seq_mul32_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [32:0] a_q, a_d;
    logic [31:0] q_q, q_d;
    logic [32:0] m_q, m_d;
    logic        q1_q, q1_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] z_q, z_d;
    logic        done_q, done_d;

    // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,q_1}.
    logic [32:0] sum;
    logic [32:0] a_sh;
    logic [31:0] q_sh;
    logic        q1_sh;

    always_comb begin
        sum = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        a_sh  = {sum[32], sum[32:1]};
        q_sh  = {sum[0], q_q[31:1]};
        q1_sh = q_q[0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    m_d     = {bus.RegA[31], bus.RegA};
                    q_d     = bus.RegB;
                    a_d     = 33'd0;
                    q1_d    = 1'b0;
                    cnt_d   = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_sh;
                q_d   = q_sh;
                q1_d  = q1_sh;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // A is sign-extended by one bit, so the low 64 bits are the exact product.
                    z_d     = {a_sh[31:0], q_sh};
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            a_q     <= 33'd0;
            q_q     <= 32'd0;
            m_q     <= 33'd0;
            q1_q    <= 1'b0;
            cnt_q   <= 5'd0;
            z_q     <= 64'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.Z    = z_q;

endmodule
